// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to rx and tx), data width,
// and the clocks-per-bit computation.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_REC_BYTE,
    S_STOP,
    S_WAIT_HIGH
  } uart_state_e;

  function automatic int unsigned cycle_count(input int unsigned clk_mhz,
                                              input int unsigned baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus a delayed copy used to
// flag a high-to-low transition of the synchronised level.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled bits, stop-bit check, valid/ready byte
// output with single-cycle framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 50,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_pin,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_data_valid,
  input  logic              rx_data_ready,
  output logic              rx_frame_err,
  output logic              rx_overrun
);

  localparam int unsigned CYCLE = cycle_count(CLK_FRE, BAUD_RATE);
  localparam int unsigned HALF  = CYCLE / 2;
  localparam logic [15:0] CYCLE_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] HALF_LAST  = 16'(HALF - 1);

  if (CYCLE < 4 || CYCLE >= 65536) begin : g_cycle_range
    $error("uart_rx: CLK_FRE/BAUD_RATE gives a bit period outside 4..65535 clocks");
  end

  logic rx_sync;
  logic rx_fall;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx_pin),
    .sync_o (rx_sync),
    .fall_o (rx_fall)
  );

  uart_state_e       state_q;
  logic [15:0]       cycle_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              frame_err_q;
  logic              overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A delivery later in this block overrides the accept-driven clear.
      if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cycle_cnt_q <= '0;
          bit_cnt_q   <= '0;
          if (rx_fall) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cycle_cnt_q == HALF_LAST) begin
            cycle_cnt_q <= '0;
            state_q     <= rx_sync ? S_IDLE : S_REC_BYTE;
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
          end
        end

        S_REC_BYTE: begin
          if (cycle_cnt_q == CYCLE_LAST) begin
            cycle_cnt_q        <= '0;
            shift_q[bit_cnt_q] <= rx_sync;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
              state_q   <= S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
          end
        end

        S_STOP: begin
          if (cycle_cnt_q == CYCLE_LAST) begin
            cycle_cnt_q <= '0;
            if (rx_sync) begin
              state_q <= S_IDLE;
              if (!valid_q || rx_data_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end else begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
          end
        end

        S_WAIT_HIGH: begin
          cycle_cnt_q <= '0;
          if (rx_sync) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;
  assign rx_frame_err  = frame_err_q;
  assign rx_overrun    = overrun_q;

endmodule
